muldiv_ctrl: RTL and testbench

Multi-cycle sequencer for the CPU's shared multiply/divide resource: the Mult and div units, the HI/LO registers, and the HI/LO source muxes. It launches the selected unit on a request from the main control FSM, then counts the unit's fixed latency. It commits the result to HI/LO with a single write strobe, or raises a divide-by-zero exception request instead. It sits between the main control unit and the HI/LO datapath and replaces ad-hoc driving of `HILO_W` and `divOrMult`.

---
 rtl/muldiv_pkg.sv | 9 +
 rtl/md_cycle_counter.sv | 18 +
 rtl/muldiv_ctrl.sv | 66 ++++++
 tb/tb_muldiv_ctrl.sv | 109 ++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared states, op encodings and default latencies for the multiply/divide sequencer
package muldiv_pkg;
    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, WRITE, EXC} md_state_t;
    localparam logic MD_OP_MULT = 1'b0;
    localparam logic MD_OP_DIV = 1'b1;
    localparam int MD_MULT_CYCLES = 32;
    localparam int MD_DIV_CYCLES = 32;
    localparam int MD_CNT_W = 6;
endpackage

// File: rtl/md_cycle_counter.sv
// md_cycle_counter: loadable down-counter that stops at zero instead of wrapping
module md_cycle_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk)
        if (reset) cnt <= '0;
        else if (load) cnt <= load_val;
        else if (en && cnt != '0) cnt <= cnt - 1'b1;
    assign zero = cnt == '0;
endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: launches the mult/div unit, counts its latency and commits HI/LO or raises div-by-zero.
// Divide-by-zero exception handling is enabled by defining MULDIV_DIV0_EXC_EN.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES,
    parameter int DIV_CYCLES = MD_DIV_CYCLES,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic op,
    input  logic div_zero,
    output logic unit_start,
    output logic div_or_mult,
    output logic hilo_w,
    output logic busy,
    output logic done,
    output logic exc_div0
);
    md_state_t state, nxt;
    logic zero;
    always_ff @(posedge clk)
        if (reset) begin
            state <= IDLE;
            div_or_mult <= MD_OP_MULT;
        end else begin
            state <= nxt;
            if (state == IDLE && start) div_or_mult <= op;
        end
    md_cycle_counter #(.CNT_W(CNT_W)) u_cnt (
        .clk(clk),
        .reset(reset),
        .load(state == LAUNCH),
        .en(state == RUN),
        .load_val(div_or_mult == MD_OP_DIV ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1)),
        .zero(zero)
    );
`ifdef MULDIV_DIV0_EXC_EN
    // the divider's zero flag is only meaningful in the cycle right after launch
    logic first_run;
    always_ff @(posedge clk)
        first_run <= !reset && state == LAUNCH;
    wire div0_hit = first_run && div_or_mult == MD_OP_DIV && div_zero;
    assign exc_div0 = state == EXC;
`else
    logic unused_div_zero;
    assign unused_div_zero = div_zero;
    wire div0_hit = 1'b0;
    assign exc_div0 = 1'b0;
`endif
    always_comb begin
        nxt = state;
        case (state)
            IDLE:    nxt = start ? LAUNCH : IDLE;
            LAUNCH:  nxt = RUN;
            RUN:     nxt = div0_hit ? EXC : zero ? WRITE : RUN;
            default: nxt = IDLE;
        endcase
    end
    assign unit_start = state == LAUNCH;
    assign hilo_w = state == WRITE;
    assign done = state == WRITE;
    assign busy = state != IDLE;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed checks of muldiv_ctrl with default and shortened multiply latency
module tb_muldiv_ctrl;
    logic clk = 1'b0;
    logic reset, start, op, div_zero, start1;
    logic us0, dom0, hw0, busy0, done0, exc0;
    logic us1, dom1, hw1, busy1, done1, exc1;
    logic [5:0] v0, v1;
    int n_cmp = 0, n_bad = 0;
    always #5 clk = ~clk;
    assign v0 = {us0, dom0, hw0, busy0, done0, exc0};
    assign v1 = {us1, dom1, hw1, busy1, done1, exc1};

    muldiv_ctrl u0 (
        .clk(clk), .reset(reset), .start(start), .op(op), .div_zero(div_zero),
        .unit_start(us0), .div_or_mult(dom0), .hilo_w(hw0), .busy(busy0), .done(done0), .exc_div0(exc0)
    );
    muldiv_ctrl #(.MULT_CYCLES(4)) u1 (
        .clk(clk), .reset(reset), .start(start1), .op(op), .div_zero(div_zero),
        .unit_start(us1), .div_or_mult(dom1), .hilo_w(hw1), .busy(busy1), .done(done1), .exc_div0(exc1)
    );

    task automatic chk(input string tag, input logic [5:0] got, input logic [5:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s got %b exp %b", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic hold(input string tag, input int n, input logic [5:0] exp, input bit sel);
        repeat (n) begin
            tick();
            chk(tag, sel ? v1 : v0, exp);
        end
    endtask

    // vector order: {unit_start, div_or_mult, hilo_w, busy, done, exc_div0}
    initial begin
        reset = 1; start = 0; op = 0; div_zero = 0; start1 = 0;
        tick(); tick();
        chk("reset0", v0, 6'b000000);
        chk("reset1", v1, 6'b000000);
        reset = 0;
        hold("idle", 1, 6'b000000, 0);
        start = 1; op = 0; tick(); start = 0; op = 1;
        chk("mult_launch", v0, 6'b100100);
        hold("mult_run", 32, 6'b000100, 0);
        hold("mult_write", 1, 6'b001110, 0);
        hold("mult_idle", 1, 6'b000000, 0);
        start = 1; op = 1; tick(); start = 0; op = 0;
        chk("div_launch", v0, 6'b110100);
        hold("div_run", 32, 6'b010100, 0);
        hold("div_write", 1, 6'b011110, 0);
        hold("div_idle", 2, 6'b010000, 0);
        start = 1; op = 1; div_zero = 1; tick(); start = 0;
        chk("div0_launch", v0, 6'b110100);
`ifdef MULDIV_DIV0_EXC_EN
        hold("div0_run", 1, 6'b010100, 0);
        hold("div0_exc", 1, 6'b010101, 0);
        hold("div0_idle", 2, 6'b010000, 0);
`else
        hold("div0_run", 32, 6'b010100, 0);
        hold("div0_write", 1, 6'b011110, 0);
        hold("div0_idle", 1, 6'b010000, 0);
`endif
        div_zero = 0;
        start = 1; op = 0; tick(); start = 0;
        chk("busy_launch", v0, 6'b100100);
        hold("busy_run", 3, 6'b000100, 0);
        tick(); start = 1; op = 1;
        chk("busy_start5", v0, 6'b000100);
        tick(); start = 0; op = 0;
        chk("busy_ign5", v0, 6'b000100);
        hold("busy_run2", 27, 6'b000100, 0);
        tick(); start = 1;
        chk("busy_write", v0, 6'b001110);
        tick();
        chk("busy_idle35", v0, 6'b000000);
        tick(); start = 0;
        chk("busy_relaunch", v0, 6'b100100);
        hold("busy_run3", 32, 6'b000100, 0);
        hold("busy_write2", 1, 6'b001110, 0);
        hold("busy_idle2", 1, 6'b000000, 0);
        start = 1; op = 1; tick(); start = 0;
        chk("rst_launch", v0, 6'b110100);
        hold("rst_run", 8, 6'b010100, 0);
        tick(); reset = 1;
        chk("rst_c10", v0, 6'b010100);
        tick(); reset = 0;
        chk("rst_c11", v0, 6'b000000);
        hold("rst_quiet", 40, 6'b000000, 0);
        start1 = 1; op = 0; tick(); start1 = 0;
        chk("m4_launch", v1, 6'b100100);
        hold("m4_run", 4, 6'b000100, 1);
        hold("m4_write", 1, 6'b001110, 1);
        tick(); start1 = 1;
        chk("m4_idle7", v1, 6'b000000);
        tick(); start1 = 0;
        chk("m4_launch2", v1, 6'b100100);
        hold("m4_run2", 4, 6'b000100, 1);
        hold("m4_write2", 1, 6'b001110, 1);
        hold("m4_idle2", 1, 6'b000000, 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
